// File: rtl/alu_result_checker.sv
// alu_result_checker: recomputes ALU results with a golden model and keeps pass/fail/skip statistics.
// Optional feature macro ALU_CHK_HALT_ON_ERR_EN: stop accepting transactions after the first mismatch.
module alu_result_checker #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [3:0]        in_sel,
    input  logic [DATA_W-1:0] in_out,
    input  logic              in_carry,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic [CNT_W-1:0]  skip_cnt,
    output logic              err,
    output logic [3:0]        fail_sel,
    output logic [DATA_W-1:0] fail_a,
    output logic [DATA_W-1:0] fail_b,
    output logic [DATA_W:0]   fail_exp,
    output logic [DATA_W:0]   fail_got
);
    typedef enum logic {RUN, HALT} state_t;
    state_t              state_q;
    logic                s1_v_q;
    logic [DATA_W-1:0]   s1_a_q, s1_b_q, s1_out_q;
    logic [3:0]          s1_sel_q;
    logic                s1_carry_q;
    logic [CNT_W-1:0]    pass_q, fail_q, skip_q, pass_d, fail_d, skip_d;
    logic                err_q;
    logic [3:0]          fail_sel_q;
    logic [DATA_W-1:0]   fail_a_q, fail_b_q;
    logic [DATA_W:0]     fail_exp_q, fail_got_q;
    logic [DATA_W:0]     sum, exp_val, got_val;
    logic [DATA_W-1:0]   exp_out;
    logic                accept, skip, hit, miss;

    assign in_ready = (state_q == RUN);
    assign accept   = in_valid && in_ready;
    assign pass_cnt = pass_q;
    assign fail_cnt = fail_q;
    assign skip_cnt = skip_q;
    assign err      = err_q;
    assign fail_sel = fail_sel_q;
    assign fail_a   = fail_a_q;
    assign fail_b   = fail_b_q;
    assign fail_exp = fail_exp_q;
    assign fail_got = fail_got_q;

    // S1: capture the accepted transaction; valid bit drops on reset so in-flight work is lost
    always_ff @(posedge clk) begin
        s1_v_q <= rst ? 1'b0 : accept;
        if (accept) begin
            s1_a_q     <= in_a;
            s1_b_q     <= in_b;
            s1_sel_q   <= in_sel;
            s1_out_q   <= in_out;
            s1_carry_q <= in_carry;
        end
    end

    // Golden model of the ALU result for the transaction held in S1
    always_comb begin
        exp_out = '0;
        case (s1_sel_q)
            4'h0: exp_out = sum[DATA_W-1:0];
            4'h1: exp_out = s1_a_q - s1_b_q;
            4'h2: exp_out = s1_a_q * s1_b_q;
            4'h3: exp_out = (s1_b_q == '0) ? '0 : s1_a_q / s1_b_q;
            4'h4: exp_out = s1_a_q << 1;
            4'h5: exp_out = s1_a_q >> 1;
            4'h6: exp_out = {s1_a_q[DATA_W-2:0], s1_a_q[DATA_W-1]};
            4'h7: exp_out = {s1_a_q[0], s1_a_q[DATA_W-1:1]};
            4'h8: exp_out = s1_a_q & s1_b_q;
            4'h9: exp_out = s1_a_q | s1_b_q;
            4'hA: exp_out = s1_a_q ^ s1_b_q;
            4'hB: exp_out = ~(s1_a_q | s1_b_q);
            4'hC: exp_out = ~(s1_a_q & s1_b_q);
            4'hD: exp_out = ~(s1_a_q ^ s1_b_q);
            4'hE: exp_out = DATA_W'(s1_a_q > s1_b_q);
            4'hF: exp_out = DATA_W'(s1_a_q == s1_b_q);
        endcase
    end

    // S2: classify the S1 transaction and form saturating counter updates
    always_comb begin
        sum     = {1'b0, s1_a_q} + {1'b0, s1_b_q};
        exp_val = {sum[DATA_W], exp_out};
        got_val = {s1_carry_q, s1_out_q};
        skip    = s1_v_q && (s1_sel_q == 4'h3) && (s1_b_q == '0);
        hit     = s1_v_q && !skip && (exp_val == got_val);
        miss    = s1_v_q && !skip && (exp_val != got_val);
        pass_d  = pass_q + CNT_W'(hit && !(&pass_q));
        fail_d  = fail_q + CNT_W'(miss && !(&fail_q));
        skip_d  = skip_q + CNT_W'(skip && !(&skip_q));
    end

    // Statistics, first-mismatch capture and run/halt state; clr drops the S2 result
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state_q    <= RUN;
            pass_q     <= '0;
            fail_q     <= '0;
            skip_q     <= '0;
            err_q      <= 1'b0;
            fail_sel_q <= '0;
            fail_a_q   <= '0;
            fail_b_q   <= '0;
            fail_exp_q <= '0;
            fail_got_q <= '0;
        end else begin
            pass_q <= pass_d;
            fail_q <= fail_d;
            skip_q <= skip_d;
            if (miss) err_q <= 1'b1;
            if (miss && !err_q) begin
                fail_sel_q <= s1_sel_q;
                fail_a_q   <= s1_a_q;
                fail_b_q   <= s1_b_q;
                fail_exp_q <= exp_val;
                fail_got_q <= got_val;
            end
`ifdef ALU_CHK_HALT_ON_ERR_EN
            if (miss) state_q <= HALT;
`endif
        end
    end
endmodule

// File: tb/tb_alu_result_checker.sv
// tb_alu_result_checker: directed self-checking bench for alu_result_checker
module tb_alu_result_checker;
    logic       clk = 1'b0, rst = 1'b1, clr = 1'b0, in_valid = 1'b0, in_carry = 1'b0;
    logic [7:0] in_a = '0, in_b = '0, in_out = '0;
    logic [3:0] in_sel = '0;
    logic       in_ready, err, s_ready, s_err;
    logic [15:0] pass_cnt, fail_cnt, skip_cnt;
    logic [1:0]  s_pass, s_fail, s_skip;
    logic [3:0]  fail_sel, s_fsel;
    logic [7:0]  fail_a, fail_b, s_fa, s_fb;
    logic [8:0]  fail_exp, fail_got, s_fexp, s_fgot;
    int checks = 0, failures = 0;
    logic [7:0] exp_tab [16] = '{8'h1A, 8'h14, 8'h45, 8'h01, 8'h2E, 8'h4B, 8'h2F, 8'hCB,
                                 8'h83, 8'h97, 8'h14, 8'h68, 8'h7C, 8'hEB, 8'h01, 8'h00};

    always #5 clk = ~clk;

    alu_result_checker #(.DATA_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sel(in_sel), .in_out(in_out), .in_carry(in_carry),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .skip_cnt(skip_cnt), .err(err),
        .fail_sel(fail_sel), .fail_a(fail_a), .fail_b(fail_b), .fail_exp(fail_exp), .fail_got(fail_got)
    );

    alu_result_checker #(.DATA_W(8), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(s_ready),
        .in_a(in_a), .in_b(in_b), .in_sel(in_sel), .in_out(in_out), .in_carry(in_carry),
        .pass_cnt(s_pass), .fail_cnt(s_fail), .skip_cnt(s_skip), .err(s_err),
        .fail_sel(s_fsel), .fail_a(s_fa), .fail_b(s_fb), .fail_exp(s_fexp), .fail_got(s_fgot)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] o, input logic c);
        in_valid = 1'b1; in_sel = s; in_a = a; in_b = b; in_out = o; in_carry = c;
        @(negedge clk);
    endtask

    task automatic send(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] o, input logic c);
        drive(s, a, b, o, c);
        in_valid = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_pass", pass_cnt, 0);
        chk("rst_fail", fail_cnt, 0);
        chk("rst_skip", skip_cnt, 0);
        chk("rst_err", err, 0);
        chk("rst_ready", in_ready, 1);

        send(4'h0, 8'hF0, 8'h20, 8'h10, 1'b1);
        chk("add_latency", pass_cnt, 0);
        @(negedge clk);
        chk("add_pass", pass_cnt, 1);
        chk("add_err", err, 0);

        send(4'h3, 8'h10, 8'h00, 8'h55, 1'b0);
        @(negedge clk);
        chk("div0_skip", skip_cnt, 1);
        chk("div0_pass", pass_cnt, 1);
        chk("div0_fail", fail_cnt, 0);

        send(4'h1, 8'h05, 8'h03, 8'h03, 1'b0);
        @(negedge clk);
        chk("sub_fail", fail_cnt, 1);
        chk("sub_err", err, 1);
        chk("sub_exp", fail_exp, 9'h002);
        chk("sub_got", fail_got, 9'h003);
        chk("sub_sel", fail_sel, 1);
        chk("sub_a", fail_a, 8'h05);
        chk("sub_b", fail_b, 8'h03);
`ifdef ALU_CHK_HALT_ON_ERR_EN
        chk("halt_ready", in_ready, 0);
        send(4'h0, 8'h01, 8'h01, 8'h02, 1'b0);
        @(negedge clk);
        chk("halt_drop_pass", pass_cnt, 1);
        chk("halt_drop_fail", fail_cnt, 1);
`else
        send(4'h8, 8'hAA, 8'h0F, 8'h00, 1'b0);
        @(negedge clk);
        chk("second_fail", fail_cnt, 2);
        chk("keep_sel", fail_sel, 1);
        chk("keep_exp", fail_exp, 9'h002);
        chk("keep_got", fail_got, 9'h003);
        chk("run_ready", in_ready, 1);
`endif
        pulse_clr();
        chk("clr_pass", pass_cnt, 0);
        chk("clr_fail", fail_cnt, 0);
        chk("clr_skip", skip_cnt, 0);
        chk("clr_err", err, 0);
        chk("clr_exp", fail_exp, 0);
        chk("clr_ready", in_ready, 1);

`ifdef ALU_CHK_HALT_ON_ERR_EN
        drive(4'h0, 8'h97, 8'h83, 8'h00, 1'b1);
        drive(4'h1, 8'h97, 8'h83, 8'h14, 1'b1);
        drive(4'h2, 8'h97, 8'h83, 8'h45, 1'b1);
        send(4'h4, 8'h97, 8'h83, 8'h2E, 1'b1);
        @(negedge clk);
        chk("hs_fail", fail_cnt, 1);
        chk("hs_pass", pass_cnt, 1);
        chk("hs_ready", in_ready, 0);
        chk("hs_err", err, 1);
        pulse_clr();
        chk("hs_clr_ready", in_ready, 1);
        chk("hs_clr_fail", fail_cnt, 0);
`endif

        for (int i = 0; i < 16; i++) drive(4'(i), 8'h97, 8'h83, exp_tab[i], 1'b1);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("stream_pass", pass_cnt, 16);
        chk("stream_fail", fail_cnt, 0);
        chk("stream_skip", skip_cnt, 0);
        chk("sat_pass", s_pass, 3);
        chk("sat_fail", s_fail, 0);
        pulse_clr();
        chk("clr2_pass", pass_cnt, 0);
        chk("clr2_sat", s_pass, 0);

        drive(4'h9, 8'h97, 8'h83, 8'h97, 1'b1);
        clr = 1'b1;
        send(4'h8, 8'h97, 8'h83, 8'h83, 1'b1);
        clr = 1'b0;
        @(negedge clk);
        chk("clr_s2_drop", pass_cnt, 1);

        send(4'hA, 8'h97, 8'h83, 8'h14, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_drop_pass", pass_cnt, 0);
        chk("rst_drop_ready", in_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
